// File: rtl/bcd_time_counter_pkg.sv
// Shared mode encodings, BCD limit constants and the per-digit BCD increment
// used by the timekeeping core.
package bcd_time_counter_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_BAD      = 2'd3
  } mode_e;

  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_00 = 8'h00;

  // Units 9 -> 0 carries into tens; callers never increment past their limit,
  // so the tens digit stays within 0..5.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] >= 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/bcd_time_counter_digits.sv
// Two-digit BCD modulo counter: counts MIN_VAL..MAX_VAL, clr loads MIN_VAL,
// reset loads RST_VAL (12 h hours reset to 12 rather than their minimum 01).
module bcd_mod_counter
  import bcd_time_counter_pkg::*;
#(
  parameter logic [7:0] MIN_VAL = BCD_00,
  parameter logic [7:0] MAX_VAL = BCD_59,
  parameter logic [7:0] RST_VAL = MIN_VAL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       wrap
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = MIN_VAL;
    end else if (inc) begin
      value_d = (value_q == MAX_VAL) ? MIN_VAL : bcd_inc(value_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= RST_VAL;
    else     value_q <= value_d;
  end

  assign value = value_q;
  assign wrap  = inc & (value_q == MAX_VAL);

endmodule

// File: rtl/bcd_time_counter.sv
// Digital clock timekeeping core: 1 Hz edge detect, sec/min/hour BCD chain,
// and a mode FSM for setting hours and minutes with blinking field blanking.
//
// state          | meaning
// MODE_RUN       | time advances on each 1 Hz rising edge, keys ignored except mode
// MODE_SET_HOUR  | inc_pulse steps hours with format wrap, ticks ignored
// MODE_SET_MIN   | inc_pulse steps minutes 59 -> 00 without carry, ticks ignored
// MODE_BAD       | unreachable encoding, recovers to MODE_RUN
module bcd_time_counter
  import bcd_time_counter_pkg::*;
#(
  parameter bit H24 = 1'b1
) (
  input  logic       clk_50m,
  input  logic       cr,
  input  logic       tick_1hz_in,
  input  logic       blink_2hz_in,
  input  logic       mode_pulse,
  input  logic       inc_pulse,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic       blank_hour,
  output logic       blank_min,
  output logic       hour_strobe
);

  localparam logic [7:0] HOUR_MIN = H24 ? BCD_00 : BCD_01;
  localparam logic [7:0] HOUR_MAX = H24 ? BCD_23 : BCD_12;
  localparam logic [7:0] HOUR_RST = H24 ? BCD_00 : BCD_12;

  mode_e mode_q, mode_d;
  logic  tick_prev_q, tick_prev_d;
  logic  blank_hour_q, blank_hour_d;
  logic  blank_min_q, blank_min_d;
  logic  hour_strobe_q, hour_strobe_d;

  logic tick;
  logic in_run, in_set_hour, in_set_min;
  logic set_inc;
  logic sec_inc, sec_clr, sec_wrap;
  logic min_inc, min_wrap;
  logic hour_inc, hour_wrap_unused;

  // Increment sources kept as plain assigns so the same-cycle carry chain
  // (sec wrap -> min inc -> min wrap -> hour inc) stays a simple forward path.
  assign tick        = tick_1hz_in & ~tick_prev_q;
  assign in_run      = (mode_q == MODE_RUN);
  assign in_set_hour = (mode_q == MODE_SET_HOUR);
  assign in_set_min  = (mode_q == MODE_SET_MIN);
  assign set_inc     = inc_pulse & ~mode_pulse;
  assign sec_inc     = in_run & tick;
  assign sec_clr     = in_set_min & mode_pulse;
  assign min_inc     = (in_run & sec_wrap) | (in_set_min & set_inc);
  assign hour_inc    = (in_run & min_wrap) | (in_set_hour & set_inc);

  bcd_mod_counter #(.MIN_VAL(BCD_00), .MAX_VAL(BCD_59), .RST_VAL(BCD_00)) u_sec (
    .clk   (clk_50m),
    .rst   (cr),
    .inc   (sec_inc),
    .clr   (sec_clr),
    .value (sec_bcd),
    .wrap  (sec_wrap)
  );

  bcd_mod_counter #(.MIN_VAL(BCD_00), .MAX_VAL(BCD_59), .RST_VAL(BCD_00)) u_min (
    .clk   (clk_50m),
    .rst   (cr),
    .inc   (min_inc),
    .clr   (1'b0),
    .value (min_bcd),
    .wrap  (min_wrap)
  );

  bcd_mod_counter #(.MIN_VAL(HOUR_MIN), .MAX_VAL(HOUR_MAX), .RST_VAL(HOUR_RST)) u_hour (
    .clk   (clk_50m),
    .rst   (cr),
    .inc   (hour_inc),
    .clr   (1'b0),
    .value (hour_bcd),
    .wrap  (hour_wrap_unused)
  );

  always_comb begin
    mode_d        = mode_q;
    tick_prev_d   = tick_1hz_in;
    blank_hour_d  = in_set_hour & blink_2hz_in;
    blank_min_d   = in_set_min & blink_2hz_in;
    hour_strobe_d = in_run & min_wrap;
    case (mode_q)
      MODE_RUN:      if (mode_pulse) mode_d = MODE_SET_HOUR;
      MODE_SET_HOUR: if (mode_pulse) mode_d = MODE_SET_MIN;
      MODE_SET_MIN:  if (mode_pulse) mode_d = MODE_RUN;
      default:       mode_d = MODE_RUN;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (cr) begin
      mode_q        <= MODE_RUN;
      tick_prev_q   <= 1'b0;
      blank_hour_q  <= 1'b0;
      blank_min_q   <= 1'b0;
      hour_strobe_q <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      tick_prev_q   <= tick_prev_d;
      blank_hour_q  <= blank_hour_d;
      blank_min_q   <= blank_min_d;
      hour_strobe_q <= hour_strobe_d;
    end
  end

  assign mode        = mode_q;
  assign blank_hour  = blank_hour_q;
  assign blank_min   = blank_min_q;
  assign hour_strobe = hour_strobe_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: 24 h and 12 h instances share stimulus and are
// compared against an integer hours/minutes/seconds reference model.
module tb_bcd_time_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic cr, tick, blink, mpulse, ipulse;
  logic [7:0] h1, m1, s1, h0, m0, s0;
  logic [1:0] md1, md0;
  logic bh1, bm1, hs1, bh0, bm0, hs0;

  bcd_time_counter #(.H24(1'b1)) u24 (
    .clk_50m(clk), .cr(cr), .tick_1hz_in(tick), .blink_2hz_in(blink),
    .mode_pulse(mpulse), .inc_pulse(ipulse),
    .hour_bcd(h1), .min_bcd(m1), .sec_bcd(s1), .mode(md1),
    .blank_hour(bh1), .blank_min(bm1), .hour_strobe(hs1)
  );

  bcd_time_counter #(.H24(1'b0)) u12 (
    .clk_50m(clk), .cr(cr), .tick_1hz_in(tick), .blink_2hz_in(blink),
    .mode_pulse(mpulse), .inc_pulse(ipulse),
    .hour_bcd(h0), .min_bcd(m0), .sec_bcd(s0), .mode(md0),
    .blank_hour(bh0), .blank_min(bm0), .hour_strobe(hs0)
  );

  int n_chk = 0;
  int n_fail = 0;

  // reference model state, index 1 = 24 h, index 0 = 12 h
  int mh[2], mm[2], ms[2];
  int mmode = 0;
  bit mprev = 0, mbh = 0, mbm = 0;
  bit mhs[2];

  logic [28:0] dut_v [2];
  assign dut_v[1] = {h1, m1, s1, md1, bh1, bm1, hs1};
  assign dut_v[0] = {h0, m0, s0, md0, bh0, bm0, hs0};

  function automatic logic [7:0] bcd(int n);
    logic [3:0] t, u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  function automatic int hour_next(int f, int h);
    if (f == 1) return (h + 1) % 24;
    return (h == 12) ? 1 : h + 1;
  endfunction

  function automatic logic [28:0] exp_v(int f);
    return {bcd(mh[f]), bcd(mm[f]), bcd(ms[f]), 2'(mmode), mbh, mbm, mhs[f]};
  endfunction

  always @(posedge clk) begin : model
    bit tk;
    if (cr) begin
      for (int f = 0; f < 2; f++) begin
        mh[f] = (f == 1) ? 0 : 12; mm[f] = 0; ms[f] = 0; mhs[f] = 0;
      end
      mmode = 0; mprev = 0; mbh = 0; mbm = 0;
    end else begin
      tk = tick && !mprev;
      for (int f = 0; f < 2; f++) begin
        mhs[f] = 0;
        case (mmode)
          0: if (tk) begin
               ms[f]++;
               if (ms[f] == 60) begin
                 ms[f] = 0; mm[f]++;
                 if (mm[f] == 60) begin
                   mm[f] = 0; mhs[f] = 1; mh[f] = hour_next(f, mh[f]);
                 end
               end
             end
          1: if (ipulse && !mpulse) mh[f] = hour_next(f, mh[f]);
          2: if (ipulse && !mpulse) mm[f] = (mm[f] + 1) % 60;
          default: ;
        endcase
        if (mpulse && mmode == 2) ms[f] = 0;
      end
      mbh = (mmode == 1) && blink;
      mbm = (mmode == 2) && blink;
      if (mpulse) mmode = (mmode + 1) % 3;
      mprev = tick;
    end
  end

  task automatic do_reset();
    cr = 1'b1;
    repeat (2) @(negedge clk);
    cr = 1'b0;
  endtask

  task automatic pulse_mode();
    mpulse = 1'b1; @(negedge clk); mpulse = 1'b0;
  endtask

  task automatic pulse_inc();
    ipulse = 1'b1; @(negedge clk); ipulse = 1'b0;
  endtask

  task automatic do_tick(int n);
    repeat (n) begin
      tick = 1'b1; @(negedge clk);
      tick = 1'b0; @(negedge clk);
    end
  endtask

  task automatic set_time(int hinc, int minc);
    pulse_mode(); @(negedge clk);
    repeat (hinc) begin pulse_inc(); @(negedge clk); end
    pulse_mode(); @(negedge clk);
    repeat (minc) begin pulse_inc(); @(negedge clk); end
    pulse_mode(); @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (40) begin
      tick = 1'($urandom); mpulse = ($urandom_range(0, 5) == 0);
      ipulse = 1'($urandom); blink = 1'($urandom);
      @(negedge clk);
    end
    mpulse = 0; ipulse = 0; tick = 0; blink = 0;
    do_reset();
    n_chk++;
    if (dut_v[1] !== {24'h000000, 2'd0, 3'b000}) begin
      n_fail++; $display("FAIL reset_24h: got %h want %h", dut_v[1], {24'h000000, 2'd0, 3'b000});
    end
    n_chk++;
    if (dut_v[0] !== {24'h120000, 2'd0, 3'b000}) begin
      n_fail++; $display("FAIL reset_12h: got %h want %h", dut_v[0], {24'h120000, 2'd0, 3'b000});
    end
  endtask

  task automatic test_tick_carry();
    do_reset();
    set_time(23, 59);
    do_tick(58);
    n_chk++;
    if ({h1, m1, s1} !== 24'h235958) begin
      n_fail++; $display("FAIL carry_preload: got %h want 235958", {h1, m1, s1});
    end
    do_tick(1);
    n_chk++;
    if ({h1, m1, s1, hs1} !== {24'h235959, 1'b0}) begin
      n_fail++; $display("FAIL carry_59: got %h strobe %b want 235959 strobe 0", {h1, m1, s1}, hs1);
    end
    tick = 1'b1; @(negedge clk);
    n_chk++;
    if ({h1, m1, s1, hs1} !== {24'h000000, 1'b1}) begin
      n_fail++; $display("FAIL carry_wrap: got %h strobe %b want 000000 strobe 1", {h1, m1, s1}, hs1);
    end
    for (int f = 0; f < 2; f++) begin
      n_chk++;
      if (dut_v[f] !== exp_v(f)) begin
        n_fail++; $display("FAIL carry_model[%0d]: got %h want %h", f, dut_v[f], exp_v(f));
      end
    end
    tick = 1'b0; @(negedge clk);
    n_chk++;
    if (hs1 !== 1'b0) begin
      n_fail++; $display("FAIL strobe_width: got %b want 0", hs1);
    end
    tick = 1'b1;
    repeat (100) @(negedge clk);
    tick = 1'b0; @(negedge clk);
    n_chk++;
    if ({h1, m1, s1} !== 24'h000001) begin
      n_fail++; $display("FAIL tick_held: got %h want 000001", {h1, m1, s1});
    end
  endtask

  task automatic test_12h_wrap();
    do_reset();
    set_time(0, 59);
    do_tick(59);
    n_chk++;
    if ({h0, m0, s0} !== 24'h125959) begin
      n_fail++; $display("FAIL h12_preload: got %h want 125959", {h0, m0, s0});
    end
    tick = 1'b1; @(negedge clk);
    n_chk++;
    if ({h0, m0, s0, hs0} !== {24'h010000, 1'b1}) begin
      n_fail++; $display("FAIL h12_wrap: got %h strobe %b want 010000 strobe 1", {h0, m0, s0}, hs0);
    end
    tick = 1'b0; @(negedge clk);
    do_reset();
    pulse_mode(); @(negedge clk);
    pulse_inc();
    n_chk++;
    if ({h0, md0} !== {8'h01, 2'd1}) begin
      n_fail++; $display("FAIL h12_set_inc: got hour %h mode %0d want hour 01 mode 1", h0, md0);
    end
    pulse_mode(); @(negedge clk);
    pulse_mode(); @(negedge clk);
  endtask

  task automatic test_set_modes();
    do_reset();
    do_tick(5);
    pulse_mode();
    n_chk++;
    if (md1 !== 2'd1) begin n_fail++; $display("FAIL mode_step1: got %0d want 1", md1); end
    pulse_mode();
    n_chk++;
    if (md1 !== 2'd2) begin n_fail++; $display("FAIL mode_step2: got %0d want 2", md1); end
    repeat (59) begin pulse_inc(); @(negedge clk); end
    pulse_inc();
    n_chk++;
    if ({h1, m1, h0, m0, hs1, hs0} !== {32'h00001200, 2'b00}) begin
      n_fail++; $display("FAIL setmin_wrap: got %h %h %h %h strobe %b%b want 00 00 12 00 strobe 00",
                         h1, m1, h0, m0, hs1, hs0);
    end
    do_tick(3);
    n_chk++;
    if (s1 !== 8'h05) begin n_fail++; $display("FAIL tick_in_set: got %h want 05", s1); end
    pulse_mode();
    n_chk++;
    if ({md1, s1} !== {2'd0, 8'h00}) begin
      n_fail++; $display("FAIL return_run: got mode %0d sec %h want mode 0 sec 00", md1, s1);
    end
  endtask

  task automatic test_blink_priority();
    do_reset();
    pulse_mode(); @(negedge clk);
    blink = 1'b1; @(negedge clk);
    n_chk++;
    if ({bh1, bm1} !== 2'b10) begin
      n_fail++; $display("FAIL blank_hour: got %b%b want 10", bh1, bm1);
    end
    mpulse = 1'b1; ipulse = 1'b1; @(negedge clk);
    mpulse = 1'b0; ipulse = 1'b0;
    n_chk++;
    if ({md1, h1, h0} !== {2'd2, 8'h00, 8'h12}) begin
      n_fail++; $display("FAIL mode_inc_prio: got mode %0d hours %h %h want 2 00 12", md1, h1, h0);
    end
    @(negedge clk);
    n_chk++;
    if ({bh1, bm1} !== 2'b01) begin
      n_fail++; $display("FAIL blank_min: got %b%b want 01", bh1, bm1);
    end
    blink = 1'b0;
    pulse_mode(); @(negedge clk);
  endtask

  task automatic test_reset_mid_carry();
    do_reset();
    set_time(23, 59);
    do_tick(59);
    tick = 1'b1; cr = 1'b1; @(negedge clk);
    cr = 1'b0; tick = 1'b0;
    n_chk++;
    if (dut_v[1] !== {24'h000000, 2'd0, 3'b000}) begin
      n_fail++; $display("FAIL reset_carry_24h: got %h want %h", dut_v[1], {24'h000000, 2'd0, 3'b000});
    end
    n_chk++;
    if (dut_v[0] !== {24'h120000, 2'd0, 3'b000}) begin
      n_fail++; $display("FAIL reset_carry_12h: got %h want %h", dut_v[0], {24'h120000, 2'd0, 3'b000});
    end
    @(negedge clk);
    n_chk++;
    if ({hs1, hs0, s1} !== {2'b00, 8'h00}) begin
      n_fail++; $display("FAIL reset_carry_after: strobe %b%b sec %h want 00 00", hs1, hs0, s1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      cr     = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 1) == 0) tick = ~tick;
      if ($urandom_range(0, 15) == 0) blink = ~blink;
      mpulse = ($urandom_range(0, 29) == 0);
      ipulse = ($urandom_range(0, 1) == 0);
      @(negedge clk);
      for (int f = 0; f < 2; f++) begin
        n_chk++;
        if (dut_v[f] !== exp_v(f)) begin
          n_fail++; $display("FAIL random[%0d] cycle %0d: got %h want %h", f, i, dut_v[f], exp_v(f));
        end
      end
    end
    cr = 0; tick = 0; mpulse = 0; ipulse = 0; blink = 0;
  endtask

  initial begin
    cr = 1'b1; tick = 1'b0; blink = 1'b0; mpulse = 1'b0; ipulse = 1'b0;
    @(negedge clk);
    cr = 1'b0;
    test_reset();
    test_tick_carry();
    test_12h_wrap();
    test_set_modes();
    test_blink_priority();
    test_reset_mid_carry();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
